blk_darken: RTL and testbench

- Read side of the per-block dark map.
- Tracks pixel position in the live video stream and emits block-boundary strobes h_save_o/v_save_o, which drive the block buffer.
- Consumes the block decision bit rx_i and inverts pixels of blocks flagged dark, delaying sync/data by a fixed pipeline.
- Sits between the video input timing and the output encoder, alongside the block buffer.

---
 rtl/blk_darken_pkg.sv | 28 ++
 rtl/blk_darken_if.sv | 13 +
 rtl/blk_darken_blk_pos_counter.sv | 53 +++++
 rtl/blk_darken.sv | 151 +++++++++++++++
 tb/tb_blk_darken.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/blk_darken_pkg.sv
// Shared types and defaults for the block-darken read path.
package blk_darken_pkg;

  localparam int unsigned PX_W = 24;

  // Channel slices of an {R,G,B} pixel
  localparam int unsigned R_HI = 23;
  localparam int unsigned R_LO = 16;
  localparam int unsigned G_HI = 15;
  localparam int unsigned G_LO = 8;
  localparam int unsigned B_HI = 7;
  localparam int unsigned B_LO = 0;

  localparam int unsigned DEF_HBLKS = 10;
  localparam int unsigned DEF_VBLKS = 10;
  localparam int unsigned DEF_BLK_W = 30;
  localparam int unsigned DEF_BLK_H = 30;

  typedef logic [PX_W-1:0] pixel_t;

  // Per-channel inversion of a pixel when its block is dark
  function automatic pixel_t px_apply_dark(input pixel_t px, input logic dark);
    return {px[R_HI:R_LO] ^ {8{dark}},
            px[G_HI:G_LO] ^ {8{dark}},
            px[B_HI:B_LO] ^ {8{dark}}};
  endfunction

endpackage

// File: rtl/blk_darken_if.sv
// Video stream bundle: syncs, data enable and RGB pixel.
interface blk_darken_if;
  import blk_darken_pkg::*;

  logic   vs;
  logic   hs;
  logic   de;
  pixel_t data;

  modport master (output vs, hs, de, data);
  modport slave  (input  vs, hs, de, data);

endinterface

// File: rtl/blk_darken_blk_pos_counter.sv
// Position-within-block counter with block index; saturates after the last block.
module blk_pos_counter #(
  parameter  int unsigned BLK_SIZE  = 30,
  parameter  int unsigned BLK_COUNT = 10,
  localparam int unsigned CW = (BLK_SIZE > 1) ? $clog2(BLK_SIZE) : 1,
  localparam int unsigned BW = $clog2(BLK_COUNT + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  input  logic          step_i,
  output logic [CW-1:0] cnt_o,
  output logic [BW-1:0] blk_o,
  output logic          wrap_o,
  output logic          sat_o
);

  logic [CW-1:0] cnt_q, cnt_eff;
  logic [BW-1:0] blk_q, blk_eff;
  logic          last;

  // A clear in the same cycle as a step counts that step as position 0
  always_comb begin
    cnt_eff = clear_i ? '0 : cnt_q;
    blk_eff = clear_i ? '0 : blk_q;
    sat_o   = (blk_eff == BW'(BLK_COUNT));
    last    = (cnt_eff == CW'(BLK_SIZE - 1));
    wrap_o  = step_i && !sat_o && last;
  end

  // Position / block registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      blk_q <= '0;
    end else if (step_i && !sat_o) begin
      if (last) begin
        cnt_q <= '0;
        blk_q <= blk_eff + BW'(1);
      end else begin
        cnt_q <= cnt_eff + CW'(1);
        blk_q <= blk_eff;
      end
    end else if (clear_i) begin
      cnt_q <= '0;
      blk_q <= '0;
    end
  end

  assign cnt_o = cnt_q;
  assign blk_o = blk_q;

endmodule

// File: rtl/blk_darken.sv
// Block-darken read side: block-boundary strobes and dark-block pixel inversion.
module blk_darken
  import blk_darken_pkg::*;
#(
  parameter int unsigned HBLKS = DEF_HBLKS,
  parameter int unsigned VBLKS = DEF_VBLKS,
  parameter int unsigned BLK_W = DEF_BLK_W,
  parameter int unsigned BLK_H = DEF_BLK_H
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  blk_darken_if.slave  vid_i,
  input  logic         rx_i,
  input  logic         en_i,
  output logic         h_save_o,
  output logic         v_save_o,
  blk_darken_if.master vid_o,
  output logic         frame_err_o
);

  localparam int unsigned H_TOT = HBLKS * BLK_W;
  localparam int unsigned PCW   = $clog2(H_TOT + 1);
  localparam int unsigned HCW   = (BLK_W > 1) ? $clog2(BLK_W) : 1;
  localparam int unsigned HBW   = $clog2(HBLKS + 1);
  localparam int unsigned VCW   = (BLK_H > 1) ? $clog2(BLK_H) : 1;
  localparam int unsigned VBW   = $clog2(VBLKS + 1);

  logic           vs_q, de_q, synced_q, armed_q, h_over_q, v_over_q;
  logic [PCW-1:0] pix_q;
  logic           vs_rise, de_rise, de_fall;
  logic           h_clear, h_step, v_step;
  logic           h_wrap, h_sat, v_wrap, v_sat;
  logic           pix_err, line_err, dark_s0;
  logic [HCW-1:0] hcnt_unused;
  logic [HBW-1:0] hblk_unused;
  logic [VCW-1:0] vcnt;
  logic [VBW-1:0] vblk;

  logic           vs1, hs1, de1, dark1, vs2, hs2, de2;
  pixel_t         data1, data2;

  // Edge detection and counter control; nothing counts until the first vs after reset
  always_comb begin
    vs_rise  = vid_i.vs & ~vs_q;
    de_rise  = vid_i.de & ~de_q;
    de_fall  = ~vid_i.de & de_q;
    h_clear  = synced_q & de_rise;
    h_step   = synced_q & vid_i.de;
    v_step   = synced_q & de_fall;
    dark_s0  = en_i & rx_i & h_step & ~h_sat;
    pix_err  = v_step & ((pix_q != PCW'(H_TOT)) | h_over_q);
    line_err = vs_rise & armed_q &
               ((vblk != VBW'(VBLKS)) | (vcnt != '0) | v_over_q);
  end

  blk_pos_counter #(
    .BLK_SIZE  (BLK_W),
    .BLK_COUNT (HBLKS)
  ) u_hpos (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (h_clear),
    .step_i  (h_step),
    .cnt_o   (hcnt_unused),
    .blk_o   (hblk_unused),
    .wrap_o  (h_wrap),
    .sat_o   (h_sat)
  );

  blk_pos_counter #(
    .BLK_SIZE  (BLK_H),
    .BLK_COUNT (VBLKS)
  ) u_vpos (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (vs_rise),
    .step_i  (v_step),
    .cnt_o   (vcnt),
    .blk_o   (vblk),
    .wrap_o  (v_wrap),
    .sat_o   (v_sat)
  );

  // Sync history, frame sync/arm flags and overflow markers for the error checks
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      vs_q     <= 1'b0;
      de_q     <= 1'b0;
      synced_q <= 1'b0;
      armed_q  <= 1'b0;
      h_over_q <= 1'b0;
      v_over_q <= 1'b0;
    end else begin
      vs_q <= vid_i.vs;
      de_q <= vid_i.de;
      if (vs_rise) begin
        synced_q <= 1'b1;
        armed_q  <= 1'b1;
        v_over_q <= 1'b0;
      end else if (v_step && v_sat) begin
        v_over_q <= 1'b1;
      end
      if (h_clear) h_over_q <= 1'b0;
      else if (h_step && h_sat) h_over_q <= 1'b1;
    end
  end

  // Saturating pixels-per-line counter
  always_ff @(posedge clk_i) begin
    if (!rst_ni) pix_q <= '0;
    else if (h_clear) pix_q <= PCW'(1);
    else if (h_step && (pix_q != '1)) pix_q <= pix_q + PCW'(1);
  end

  // Block strobes and sticky frame error
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      h_save_o    <= 1'b0;
      v_save_o    <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      h_save_o <= h_wrap;
      v_save_o <= v_wrap;
      if (pix_err || line_err) frame_err_o <= 1'b1;
    end
  end

  // Two-stage pixel pipeline; inversion applied in the second stage
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      vs1 <= 1'b0; hs1 <= 1'b0; de1 <= 1'b0; dark1 <= 1'b0; data1 <= '0;
      vs2 <= 1'b0; hs2 <= 1'b0; de2 <= 1'b0; data2 <= '0;
    end else begin
      vs1   <= vid_i.vs;
      hs1   <= vid_i.hs;
      de1   <= vid_i.de;
      data1 <= vid_i.data;
      dark1 <= dark_s0;
      vs2   <= vs1;
      hs2   <= hs1;
      de2   <= de1;
      data2 <= px_apply_dark(data1, dark1);
    end
  end

  assign vid_o.vs   = vs2;
  assign vid_o.hs   = hs2;
  assign vid_o.de   = de2;
  assign vid_o.data = data2;

endmodule

// File: tb/tb_blk_darken.sv
// Directed scoreboard bench for blk_darken (3x2 blocks of 4x2 pixels).
module tb_blk_darken;
  import blk_darken_pkg::*;

  localparam int HB = 3;
  localparam int BW = 4;
  localparam int VB = 2;
  localparam int BH = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic rx, en;
  logic h_save, v_save, ferr;

  blk_darken_if vin ();
  blk_darken_if vout ();

  blk_darken #(
    .HBLKS (HB),
    .VBLKS (VB),
    .BLK_W (BW),
    .BLK_H (BH)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .vid_i       (vin),
    .rx_i        (rx),
    .en_i        (en),
    .h_save_o    (h_save),
    .v_save_o    (v_save),
    .vid_o       (vout),
    .frame_err_o (ferr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic        vs;
    logic        hs;
    logic        de;
    logic [23:0] data;
  } pix_exp_t;

  typedef struct {
    int   due;
    logic h;
    logic v;
  } strb_exp_t;

  pix_exp_t  pq[$];
  strb_exp_t sq[$];
  int cyc     = 0;
  int checks  = 0;
  int errors  = 0;
  int line_no = 0;

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic chk_px(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Pop and compare every expectation that falls due in the current cycle
  task automatic drain();
    pix_exp_t  pe;
    strb_exp_t se;
    while (pq.size() > 0 && pq[0].due <= cyc) begin
      pe = pq.pop_front();
      chk_bit("vs_o", vout.vs, pe.vs);
      chk_bit("hs_o", vout.hs, pe.hs);
      chk_bit("de_o", vout.de, pe.de);
      chk_px("data_o", vout.data, pe.data);
    end
    while (sq.size() > 0 && sq[0].due <= cyc) begin
      se = sq.pop_front();
      chk_bit("h_save_o", h_save, se.h);
      chk_bit("v_save_o", v_save, se.v);
    end
  endtask

  task automatic step(input logic v_s, input logic h_s, input logic d_e,
                      input logic [23:0] d, input logic r, input logic dark,
                      input logic hx, input logic vx);
    vin.vs   = v_s;
    vin.hs   = h_s;
    vin.de   = d_e;
    vin.data = d;
    rx       = r;
    pq.push_back('{due: cyc + 2, vs: v_s, hs: h_s, de: d_e, data: (dark ? ~d : d)});
    sq.push_back('{due: cyc + 1, h: hx, v: vx});
    @(posedge clk);
    cyc++;
    #1;
    drain();
  endtask

  task automatic vsync();
    step(1'b1, 1'b0, 1'b0, 24'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 24'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 24'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    line_no = 0;
  endtask

  // Pixels beyond the 12 valid ones use rx_mask[3]
  task automatic pixel(input int p, input logic [3:0] rx_mask, input logic [23:0] d);
    int   b;
    logic r, inr;
    inr = (p < HB * BW);
    b   = inr ? p / BW : HB;
    r   = rx_mask[b];
    step(1'b0, 1'b0, 1'b1, d, r, en & r & inr, inr && (p % BW == BW - 1), 1'b0);
  endtask

  task automatic line_end(input logic vx);
    step(1'b0, 1'b0, 1'b0, 24'h0, 1'b0, 1'b0, 1'b0, vx);
    step(1'b0, 1'b1, 1'b0, 24'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 24'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    line_no++;
  endtask

  task automatic line(input int npix, input logic [3:0] rx_mask, input logic [23:0] d);
    for (int p = 0; p < npix; p++) pixel(p, rx_mask, d);
    line_end((line_no % BH == BH - 1) && (line_no < VB * BH));
  endtask

  task automatic do_reset(input logic d_e, input logic [23:0] d);
    rst_n    = 1'b0;
    vin.vs   = 1'b0;
    vin.hs   = 1'b0;
    vin.de   = d_e;
    vin.data = d;
    @(posedge clk);
    cyc++;
    #1;
    chk_bit("rst_h_save", h_save, 1'b0);
    chk_bit("rst_v_save", v_save, 1'b0);
    chk_bit("rst_frame_err", ferr, 1'b0);
    chk_bit("rst_vs_o", vout.vs, 1'b0);
    chk_bit("rst_hs_o", vout.hs, 1'b0);
    chk_bit("rst_de_o", vout.de, 1'b0);
    chk_px("rst_data_o", vout.data, 24'h0);
    pq.delete();
    sq.delete();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b0;
    rx       = 1'b0;
    en       = 1'b0;
    vin.vs   = 1'b0;
    vin.hs   = 1'b0;
    vin.de   = 1'b0;
    vin.data = '0;
    #1;

    // Reset state
    do_reset(1'b0, 24'h0);
    do_reset(1'b0, 24'h0);

    // Full frame of four good lines; block 1 of line 1 dark
    vsync();
    chk_bit("first_vs_no_check", ferr, 1'b0);
    line(12, 4'b0000, 24'h102030);
    chk_bit("err_after_line0", ferr, 1'b0);
    en = 1'b1;
    line(12, 4'b0010, 24'h102030);
    chk_bit("err_after_line1", ferr, 1'b0);
    en = 1'b0;
    line(12, 4'b0111, 24'hA5C3F0);
    line(12, 4'b0000, 24'h5A3C0F);
    vsync();
    chk_bit("err_good_frame", ferr, 1'b0);

    // Over-long line: no fourth strobe, overflow pixels not inverted, error latched
    en = 1'b1;
    line(14, 4'b1111, 24'h102030);
    chk_bit("err_long_line", ferr, 1'b1);

    // Five lines in a frame: two row strobes, error at next vs
    do_reset(1'b0, 24'h0);
    vsync();
    chk_bit("err_first_vs_after_rst", ferr, 1'b0);
    en = 1'b0;
    for (int l = 0; l < 5; l++) line(12, 4'b0000, 24'h00FF00 + 24'(l));
    chk_bit("err_before_vs", ferr, 1'b0);
    vsync();
    chk_bit("err_extra_lines", ferr, 1'b1);

    // Reset at pixel 6, tail of that line ignored, then a clean line
    do_reset(1'b0, 24'h0);
    vsync();
    en = 1'b1;
    for (int p = 0; p < 6; p++) pixel(p, 4'b0010, 24'h102030);
    do_reset(1'b1, 24'h102030);
    for (int p = 6; p < 12; p++)
      step(1'b0, 1'b0, 1'b1, 24'h102030, 1'b1, 1'b0, 1'b0, 1'b0);
    line_end(1'b0);
    chk_bit("err_unsynced_line", ferr, 1'b0);
    vsync();
    en = 1'b0;
    line(12, 4'b0000, 24'h123456);
    chk_bit("err_clean_after_rst", ferr, 1'b0);

    step(1'b0, 1'b0, 1'b0, 24'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 24'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    if (pq.size() > 2 || sq.size() > 1) begin
      errors++;
      $display("FAIL scoreboard_leftover observed=%0d/%0d expected<=2/1", pq.size(), sq.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
